// File: rtl/speed_pkg.sv
// Shared types and level table for the speed governor.
// Provides speed_params_t (gravity / duck limit / jump velocity per level)
// and level_params(), which maps a speed level to its physics entry.
package speed_pkg;

    localparam int unsigned PARAM_FW = 16;

    // Largest value each output must carry across all levels.
    localparam int unsigned MAX_GRAVITY = 60;
    localparam int unsigned MAX_DUCK    = 128;
    localparam int unsigned MAX_JUMP    = 420;

    typedef struct packed {
        logic [PARAM_FW-1:0] gravity;
        logic [PARAM_FW-1:0] duck_limit;
        logic [PARAM_FW-1:0] vertical_jump;
    } speed_params_t;

    // Index 0 holds L0, index 3 holds L3.
    localparam logic [3:0][PARAM_FW-1:0] GRAVITY_TBL = {16'd60, 16'd15, 16'd4,  16'd1};
    localparam logic [3:0][PARAM_FW-1:0] DUCK_TBL    = {16'd16, 16'd32, 16'd64, 16'd128};
    localparam logic [3:0][PARAM_FW-1:0] JUMP_TBL    = {16'd360, 16'd420, 16'd220, 16'd108};

    // Levels beyond L3 reuse the L3 entry but keep halving the duck limit,
    // bottoming out at one frame.
    function automatic speed_params_t level_params(input int unsigned level);
        speed_params_t p;
        logic [1:0]    idx;
        if (level < 4) begin
            idx             = level[1:0];
            p.gravity       = GRAVITY_TBL[idx];
            p.duck_limit    = DUCK_TBL[idx];
            p.vertical_jump = JUMP_TBL[idx];
        end else begin
            p.gravity       = GRAVITY_TBL[3];
            p.vertical_jump = JUMP_TBL[3];
            p.duck_limit    = (level < 8) ? PARAM_FW'(32'd128 >> level) : PARAM_FW'(1);
        end
        return p;
    endfunction

endpackage

// File: rtl/speed_governor_if.sv
// Control/status bundle between the game-state FSM / player physics (master)
// and the speed governor (slave).
//   frame_tick_in, run_in, grounded_in, slow_req_in, restart_in : to governor
//   level_out, speed_out, gravity_out, duck_limit_out,
//   vertical_jump_out, pending_out, update_out                  : from governor
interface speed_governor_if #(
    parameter int unsigned NUM_LEVELS = 4,
    parameter int unsigned GRAV_W     = 6,
    parameter int unsigned DUCK_W     = 8,
    parameter int unsigned JUMP_W     = 10
);
    localparam int unsigned LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

    logic                  frame_tick_in;
    logic                  run_in;
    logic                  grounded_in;
    logic                  slow_req_in;
    logic                  restart_in;
    logic [LVL_W-1:0]      level_out;
    logic [NUM_LEVELS-1:0] speed_out;
    logic [GRAV_W-1:0]     gravity_out;
    logic [DUCK_W-1:0]     duck_limit_out;
    logic [JUMP_W-1:0]     vertical_jump_out;
    logic                  pending_out;
    logic                  update_out;

    modport master (
        output frame_tick_in, run_in, grounded_in, slow_req_in, restart_in,
        input  level_out, speed_out, gravity_out, duck_limit_out,
               vertical_jump_out, pending_out, update_out
    );

    modport slave (
        input  frame_tick_in, run_in, grounded_in, slow_req_in, restart_in,
        output level_out, speed_out, gravity_out, duck_limit_out,
               vertical_jump_out, pending_out, update_out
    );

endinterface

// File: rtl/speed_ramp_counter.sv
// Frame counter and target speed level.
// Ports: clk_in/rst_in (sync, active-high), frame_tick_in, run_in,
// slow_req_in, restart_in in; target_out (uncommitted target level) and
// count_out (frames spent at the current target) out.
// Priority: reset/restart > slowdown > ramp.
module speed_ramp_counter #(
    parameter int unsigned NUM_LEVELS       = 4,
    parameter int unsigned FRAMES_PER_LEVEL = 1800,
    localparam int unsigned LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int unsigned CNT_W = (FRAMES_PER_LEVEL > 1) ? $clog2(FRAMES_PER_LEVEL) : 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             frame_tick_in,
    input  logic             run_in,
    input  logic             slow_req_in,
    input  logic             restart_in,
    output logic [LVL_W-1:0] target_out,
    output logic [CNT_W-1:0] count_out
);
    localparam logic [LVL_W-1:0] MAX_LVL  = LVL_W'(NUM_LEVELS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAMES_PER_LEVEL - 1);

    logic [LVL_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        target_d = target_q;
        cnt_d    = cnt_q;
        if (slow_req_in) begin
            // A slowdown on the wrap tick cancels that tick's ramp-up.
            target_d = (target_q != '0) ? target_q - 1'b1 : '0;
            cnt_d    = '0;
        end else if (frame_tick_in && run_in && (target_q < MAX_LVL)) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d    = '0;
                target_d = target_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || restart_in) begin
            target_q <= '0;
            cnt_q    <= '0;
        end else begin
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

    assign target_out = target_q;
    assign count_out  = cnt_q;

endmodule

// File: rtl/speed_governor.sv
// Speed governor: owns the game speed level and publishes the physics
// parameters for it. The target level from speed_ramp_counter is committed
// to the outputs only on a frame tick while the player is grounded.
// Ports: clk_in, rst_in (sync, active-high); gov (speed_governor_if.slave)
// carrying the control inputs and the registered level/param outputs.
module speed_governor
    import speed_pkg::*;
#(
    parameter int unsigned NUM_LEVELS       = 4,
    parameter int unsigned FRAMES_PER_LEVEL = 1800,
    parameter int unsigned GRAV_W           = 6,
    parameter int unsigned DUCK_W           = 8,
    parameter int unsigned JUMP_W           = 10
) (
    input logic           clk_in,
    input logic           rst_in,
    speed_governor_if.slave gov
);
    localparam int unsigned LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int unsigned CNT_W = (FRAMES_PER_LEVEL > 1) ? $clog2(FRAMES_PER_LEVEL) : 1;
    localparam speed_params_t L0_PARAMS = level_params(0);

    if (NUM_LEVELS < 2) begin : g_lvl_chk
        $error("speed_governor: NUM_LEVELS must be at least 2");
    end
    if (GRAV_W < $clog2(MAX_GRAVITY + 1)) begin : g_grav_chk
        $error("speed_governor: GRAV_W cannot hold gravity 60");
    end
    if (DUCK_W < $clog2(MAX_DUCK + 1)) begin : g_duck_chk
        $error("speed_governor: DUCK_W cannot hold duck limit 128");
    end
    if (JUMP_W < $clog2(MAX_JUMP + 1)) begin : g_jump_chk
        $error("speed_governor: JUMP_W cannot hold jump velocity 420");
    end

    logic [LVL_W-1:0]      target;
    logic [CNT_W-1:0]      count_unused;
    logic                  commit;
    speed_params_t         params_d;

    logic [LVL_W-1:0]      level_q;
    logic [NUM_LEVELS-1:0] speed_q;
    logic [GRAV_W-1:0]     gravity_q;
    logic [DUCK_W-1:0]     duck_q;
    logic [JUMP_W-1:0]     jump_q;
    logic                  update_q;

    speed_ramp_counter #(
        .NUM_LEVELS       (NUM_LEVELS),
        .FRAMES_PER_LEVEL (FRAMES_PER_LEVEL)
    ) u_ramp (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .frame_tick_in (gov.frame_tick_in),
        .run_in        (gov.run_in),
        .slow_req_in   (gov.slow_req_in),
        .restart_in    (gov.restart_in),
        .target_out    (target),
        .count_out     (count_unused)
    );

    // Commit uses the target as registered at the start of this cycle, so a
    // same-cycle target change waits for the next qualifying tick.
    always_comb begin
        commit   = gov.frame_tick_in && gov.grounded_in && (level_q != target);
        params_d = level_params(32'(target));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || gov.restart_in) begin
            level_q   <= '0;
            speed_q   <= NUM_LEVELS'(1);
            gravity_q <= GRAV_W'(L0_PARAMS.gravity);
            duck_q    <= DUCK_W'(L0_PARAMS.duck_limit);
            jump_q    <= JUMP_W'(L0_PARAMS.vertical_jump);
            update_q  <= !rst_in;
        end else begin
            update_q <= commit;
            if (commit) begin
                level_q   <= target;
                speed_q   <= NUM_LEVELS'(1) << target;
                gravity_q <= GRAV_W'(params_d.gravity);
                duck_q    <= DUCK_W'(params_d.duck_limit);
                jump_q    <= JUMP_W'(params_d.vertical_jump);
            end
        end
    end

    assign gov.level_out         = level_q;
    assign gov.speed_out         = speed_q;
    assign gov.gravity_out       = gravity_q;
    assign gov.duck_limit_out    = duck_q;
    assign gov.vertical_jump_out = jump_q;
    assign gov.update_out        = update_q;
    assign gov.pending_out       = (target != level_q);

endmodule

// File: tb/tb_speed_governor.sv
// Directed bench for speed_governor with FRAMES_PER_LEVEL=4, NUM_LEVELS=4.
module tb_speed_governor;
    localparam int unsigned NL = 4;
    localparam int unsigned FPL = 4;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned upd_seen = 0;

    speed_governor_if #(.NUM_LEVELS(NL), .GRAV_W(6), .DUCK_W(8), .JUMP_W(10)) bus ();

    speed_governor #(
        .NUM_LEVELS       (NL),
        .FRAMES_PER_LEVEL (FPL),
        .GRAV_W           (6),
        .DUCK_W           (8),
        .JUMP_W           (10)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .gov    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; sample #1 after the edge.
    task automatic cyc();
        @(posedge clk_in);
        #1;
        if (bus.update_out) upd_seen++;
    endtask

    task automatic frame(input logic grounded);
        bus.grounded_in   = grounded;
        bus.frame_tick_in = 1'b1;
        cyc();
        bus.frame_tick_in = 1'b0;
    endtask

    task automatic check_params(input string tag, input int unsigned lvl, input int unsigned g,
                                input int unsigned d, input int unsigned j);
        check({tag, ".level"}, 32'(bus.level_out), lvl);
        check({tag, ".speed"}, 32'(bus.speed_out), 32'(1) << lvl);
        check({tag, ".gravity"}, 32'(bus.gravity_out), g);
        check({tag, ".duck"}, 32'(bus.duck_limit_out), d);
        check({tag, ".jump"}, 32'(bus.vertical_jump_out), j);
    endtask

    initial begin
        bus.frame_tick_in = 1'b0;
        bus.run_in        = 1'b0;
        bus.grounded_in   = 1'b0;
        bus.slow_req_in   = 1'b0;
        bus.restart_in    = 1'b0;
        cyc();
        cyc();
        rst_in = 1'b0;
        check_params("reset", 0, 1, 128, 108);
        check("reset.pending", 32'(bus.pending_out), 0);
        check("reset.update", 32'(bus.update_out), 0);
        check("reset.update_seen", upd_seen, 0);

        // Ramp to L1 and commit on the following grounded tick.
        bus.run_in = 1'b1;
        repeat (4) frame(1'b1);
        check("ramp.target", 32'(dut.u_ramp.target_q), 1);
        check("ramp.pending", 32'(bus.pending_out), 1);
        check("ramp.level_held", 32'(bus.level_out), 0);
        frame(1'b1);
        check_params("commit1", 1, 4, 64, 220);
        check("commit1.update", 32'(bus.update_out), 1);
        cyc();
        check("commit1.update_drop", 32'(bus.update_out), 0);
        check("commit1.pending", 32'(bus.pending_out), 0);
        check("commit1.count", 32'(dut.u_ramp.cnt_q), 1);

        // run_in low freezes the counter mid-count.
        bus.run_in = 1'b0;
        repeat (10) frame(1'b1);
        check("frozen.count", 32'(dut.u_ramp.cnt_q), 1);
        check("frozen.target", 32'(dut.u_ramp.target_q), 1);
        bus.run_in = 1'b1;
        repeat (2) frame(1'b1);
        check("resume.count", 32'(dut.u_ramp.cnt_q), 3);
        check("resume.target", 32'(dut.u_ramp.target_q), 1);
        frame(1'b1);
        check("resume.wrap_target", 32'(dut.u_ramp.target_q), 2);
        check("resume.wrap_count", 32'(dut.u_ramp.cnt_q), 0);
        check("resume.no_same_cycle_commit", 32'(bus.level_out), 1);
        check("resume.pending", 32'(bus.pending_out), 1);

        // Commit L2, then slowdown coinciding with the wrap.
        frame(1'b1);
        check_params("commit2", 2, 15, 32, 420);
        check("commit2.update", 32'(bus.update_out), 1);
        repeat (2) frame(1'b1);
        check("prewrap.count", 32'(dut.u_ramp.cnt_q), 3);
        bus.slow_req_in = 1'b1;
        frame(1'b1);
        bus.slow_req_in = 1'b0;
        check("slowwrap.target", 32'(dut.u_ramp.target_q), 1);
        check("slowwrap.count", 32'(dut.u_ramp.cnt_q), 0);
        check("slowwrap.pending", 32'(bus.pending_out), 1);
        check("slowwrap.level_held", 32'(bus.level_out), 2);
        check("slowwrap.update", 32'(bus.update_out), 0);
        frame(1'b1);
        check_params("slowcommit", 1, 4, 64, 220);
        check("slowcommit.update", 32'(bus.update_out), 1);
        check("slowcommit.pending", 32'(bus.pending_out), 0);

        // Restart while pending at L2 and airborne.
        repeat (3) frame(1'b0);
        check("air.target", 32'(dut.u_ramp.target_q), 2);
        check("air.pending", 32'(bus.pending_out), 1);
        check("air.level_held", 32'(bus.level_out), 1);
        bus.restart_in = 1'b1;
        cyc();
        bus.restart_in = 1'b0;
        check_params("restart", 0, 1, 128, 108);
        check("restart.update", 32'(bus.update_out), 1);
        check("restart.pending", 32'(bus.pending_out), 0);
        check("restart.target", 32'(dut.u_ramp.target_q), 0);
        check("restart.count", 32'(dut.u_ramp.cnt_q), 0);
        cyc();
        check("restart.update_drop", 32'(bus.update_out), 0);

        // Airborne through three wraps, then a single jump to L3.
        upd_seen = 0;
        repeat (12) frame(1'b0);
        check("airjump.target", 32'(dut.u_ramp.target_q), 3);
        check("airjump.pending", 32'(bus.pending_out), 1);
        check("airjump.gravity_held", 32'(bus.gravity_out), 1);
        check("airjump.no_update", upd_seen, 0);
        frame(1'b1);
        check_params("airjump", 3, 60, 16, 360);
        check("airjump.update", 32'(bus.update_out), 1);
        cyc();
        check("airjump.single_pulse", upd_seen, 1);

        // Held at max level.
        upd_seen = 0;
        repeat (20) frame(1'b1);
        check("max.count", 32'(dut.u_ramp.cnt_q), 0);
        check("max.target", 32'(dut.u_ramp.target_q), 3);
        check("max.pending", 32'(bus.pending_out), 0);
        check("max.no_update", upd_seen, 0);
        check("max.gravity", 32'(bus.gravity_out), 60);

        // Slowdown from L3 without a tick, then saturation at L0.
        bus.slow_req_in = 1'b1;
        cyc();
        bus.slow_req_in = 1'b0;
        check("slow3.target", 32'(dut.u_ramp.target_q), 2);
        check("slow3.pending", 32'(bus.pending_out), 1);
        check("slow3.level_held", 32'(bus.level_out), 3);
        bus.restart_in = 1'b1;
        cyc();
        bus.restart_in = 1'b0;
        bus.slow_req_in = 1'b1;
        cyc();
        bus.slow_req_in = 1'b0;
        check("slow0.target", 32'(dut.u_ramp.target_q), 0);
        check("slow0.pending", 32'(bus.pending_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/speed_governor.md
Name: speed_governor

Overview:
Parametrised successor to the fixed speed-to-physics lookup. It owns the game speed level, ramps it up over time, and applies slowdown requests. It publishes gravity, duck limit and jump velocity for the current level. New values are committed only on a frame boundary while the player is grounded, so a jump arc never sees a mid-air physics change. It sits between the game-state FSM and the player-physics block, and everything runs on the single system clock.

Parameters:
NUM_LEVELS, 4, number of speed levels; speed at level L is 1<<L.
FRAMES_PER_LEVEL, 1800, frame ticks spent at each level before ramping up (1800 frames = 30 s at 60 Hz).
GRAV_W, 6, gravity output width; must hold 60.
DUCK_W, 8, duck_limit width.
JUMP_W, 10, vertical_jump width.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-high reset
frame_tick_in  input  1  one-cycle pulse per video frame
run_in  input  1  game running; gates the ramp counter
grounded_in  input  1  player on ground and not ducking
slow_req_in  input  1  one-cycle pulse; drop one level
restart_in  input  1  one-cycle pulse; return to level 0
level_out  output  $clog2(NUM_LEVELS)  committed level
speed_out  output  NUM_LEVELS  one-hot speed, 1<<level_out
gravity_out  output  GRAV_W  committed gravity
duck_limit_out  output  DUCK_W  committed duck duration in frames
vertical_jump_out  output  JUMP_W  committed jump velocity
pending_out  output  1  target level differs from committed level
update_out  output  1  one-cycle pulse when the committed params change

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is synchronous and active-high. All state changes occur on the rising edge of clk_in.
- Reset values:
  - target level = 0, committed level = 0, frame counter = 0.
  - level_out = 0, speed_out = 1, gravity_out = 1, duck_limit_out = 128, vertical_jump_out = 108.
  - pending_out = 0, update_out = 0.
- Level table:
  - L0: gravity 1, duck 128, jump 108.
  - L1: gravity 4, duck 64, jump 220.
  - L2: gravity 15, duck 32, jump 420.
  - L3: gravity 60, duck 16, jump 360.
  - Levels >= 4 (when NUM_LEVELS > 4) repeat the L3 entry, except duck = max(128>>L, 1).
  - All values are zero-extended to the port widths. No silent truncation: an elaboration assertion checks that 60 fits in GRAV_W.
- Ramp counter:
  - Advances on frame_tick_in only when run_in=1 and target < NUM_LEVELS-1.
  - At FRAMES_PER_LEVEL-1 it wraps to 0 and the target level increments.
  - At max level the counter holds at 0.
  - With run_in=0 the counter holds its value.
- Slowdown:
  - slow_req_in sets target = max(target-1, 0) and clears the counter.
  - If it coincides with a counter wrap, the slowdown wins: net target = old target-1, counter = 0.
- Restart: restart_in has the highest priority and behaves like reset for all state, except that update_out pulses for one cycle.
- Commit: on a cycle with frame_tick_in=1, grounded_in=1 and committed != target (target as it was at the start of that cycle):
  - committed, level_out, speed_out and all param outputs load the target entry at that clock edge.
  - update_out=1 for exactly the following cycle. Latency is 1 clock from the qualifying tick.
  - A target change made in the same cycle commits no earlier than the next qualifying tick.
- Commit holds off while the player is airborne: if grounded_in=0, commits wait indefinitely and pending_out stays 1.
- Multi-level jumps: if the target moved by more than one level while the player was airborne, the commit jumps directly to the target. There are no intermediate steps.
- pending_out is combinational: (target != committed).
- Outputs never glitch between commits; all outputs are registered.

Decomposition:
- speed_pkg holds:
  - LEVEL table constants for gravity, duck and jump.
  - A function level_params(level), returning a packed struct {gravity, duck_limit, vertical_jump}.
  - The typedef speed_params_t.
- One sub-module, speed_ramp_counter, owns the frame counter, the target level, and the slow/restart priority logic.
- speed_governor instantiates speed_ramp_counter and holds the commit registers and update pulse.

Test Plan:
All scenarios use FRAMES_PER_LEVEL=4.
1. Reset, then 4 ticks with run_in=1 and grounded_in=1 -> target=1. On the 5th tick commit; next cycle level_out=1, speed_out=2, gravity_out=4, duck_limit_out=64, vertical_jump_out=220, update_out=1 for 1 cycle.
2. grounded_in=0 for 12 ticks from level 0 -> pending_out=1 and outputs stay at L0. On the first grounded tick, commit jumps straight to L3: gravity_out=60 (not 12), duck 16, jump 360; a single update_out pulse.
3. slow_req_in on the same tick as the counter wrap at target 2 -> target=1, counter=0. The next grounded tick commits L1.
4. At L3, 20 further ticks -> counter stays 0, target stays 3, pending_out=0, no update_out.
5. restart_in while pending at L2 and airborne -> next cycle all outputs at L0 values, update_out=1, pending_out=0.
6. run_in=0 for 10 ticks mid-count -> counter frozen. After run_in returns, the remaining ticks complete the level.
